// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/function codes and mult_hilo_unit state encoding
package mips_defs;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J         = 6'b000010;
  localparam logic [5:0] OP_BEQ       = 6'b000100;
  localparam logic [5:0] OP_ADDI      = 6'b001000;
  localparam logic [5:0] OP_LW        = 6'b100011;
  localparam logic [5:0] OP_SW        = 6'b101011;

  localparam logic [5:0] FUNC_MFHI = 6'b010000;
  localparam logic [5:0] FUNC_MFLO = 6'b010010;
  localparam logic [5:0] FUNC_MULT = 6'b011000;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_mf(input logic [5:0] func);
    return (func == FUNC_MFHI) || (func == FUNC_MFLO);
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// rtl/mult_shift_add_core.sv - unsigned shift-add multiply datapath, one partial product per step
module mult_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;

  // acc already includes this cycle's partial product, so the final step's
  // sum can be captured into HI/LO on the same edge that performs it.
  assign acc = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
    end else if (load) begin
      mcand_r  <= {{WIDTH{1'b0}}, mcand};
      mplier_r <= mplier;
      acc_r    <= '0;
    end else if (step) begin
      acc_r    <= acc;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - multi-cycle signed MULT with HI/LO registers and MFHI/MFLO read path
module mult_hilo_unit
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       instFunc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             mf_valid
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               neg;
  logic               start;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;

  assign start    = inst_valid && (opcode == OPCODE_RTYPE) && (instFunc == FUNC_MULT);
  assign mf_valid = inst_valid && (opcode == OPCODE_RTYPE) && is_mf(instFunc);
  assign rd_data  = (instFunc == FUNC_MFHI) ? hi : lo;

  // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
  assign mag_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
  assign mag_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

  assign load = (state == ST_IDLE) && start;
  assign step = (state == ST_RUN);
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .mcand  (mag_a),
    .mplier (mag_b),
    .acc    (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            count <= CW'(WIDTH - 1);
            neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
          end
        end
        ST_RUN: begin
          if (count == '0) begin
            {hi, lo} <= neg ? (~prod + 1'b1) : prod;
            state    <= ST_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - scoreboard bench for mult_hilo_unit with directed vectors
module tb_mult_hilo_unit;
  import mips_defs::*;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [5:0]  opcode;
  logic [5:0]  instFunc;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        mf_valid;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   passed;
  int   busy_cnt;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .opcode     (opcode),
    .instFunc   (instFunc),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .rd_data    (rd_data),
    .mf_valid   (mf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [5:0] func, input logic [31:0] a, input logic [31:0] b);
    inst_valid = v;
    opcode     = OPCODE_RTYPE;
    instFunc   = func;
    op_a       = a;
    op_b       = b;
  endtask

  // Returns at posedge+1 of the first RUN cycle.
  task automatic issue_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    @(posedge clk);
    #1;
    sb.push_back(e);
    drive(1'b1, FUNC_MULT, a, b);
    @(posedge clk);
    #1;
    drive(1'b0, 6'b0, 32'h0, 32'h0);
  endtask

  // Returns at the negedge of the DONE cycle.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      $display("FAIL wait_done: got timeout after %0d cycles want done pulse", n);
    end
  endtask

  task automatic mf_read(input logic [5:0] func, input logic [31:0] exp, input string name);
    drive(1'b1, func, 32'h0, 32'h0);
    #1;
    check32({name, "_rd_data"}, rd_data, exp);
    check32({name, "_mf_valid"}, {31'b0, mf_valid}, 32'h1);
    drive(1'b0, 6'b0, 32'h0, 32'h0);
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    issue_mult(a, b, eh, el);
    wait_done();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done=1 want no pending result");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check32("hi", hi, e.hi);
          check32("lo", lo, e.lo);
          check32("busy_cycles", busy_cnt, 32);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total    = 0;
    passed   = 0;
    busy_cnt = 0;
    rst      = 1'b1;
    drive(1'b0, 6'b0, 32'h0, 32'h0);
    #12;
    check32("reset_busy", {31'b0, busy}, 32'h0);
    check32("reset_done", {31'b0, done}, 32'h0);
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_mult(32'd7, 32'd6, 32'h0, 32'h0000002A);

    run_mult(32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    mf_read(FUNC_MFHI, 32'hFFFFFFFF, "mfhi_neg");
    mf_read(FUNC_MFLO, 32'hFFFFFFF1, "mflo_neg");
    drive(1'b1, FUNC_ADD, 32'h0, 32'h0);
    #1;
    check32("add_not_mf", {31'b0, mf_valid}, 32'h0);
    check32("add_rd_lo", rd_data, 32'hFFFFFFF1);
    drive(1'b0, 6'b0, 32'h0, 32'h0);

    run_mult(32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_mult(32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    run_mult(32'h00000000, 32'h00001234, 32'h0, 32'h0);

    // Second MULT in RUN is dropped; another in DONE is dropped too.
    issue_mult(32'h00012345, 32'h10, 32'h0, 32'h00123450);
    repeat (9) @(posedge clk);
    #1;
    drive(1'b1, FUNC_MULT, 32'd2, 32'd2);
    @(posedge clk);
    #1;
    drive(1'b0, 6'b0, 32'h0, 32'h0);
    wait_done();
    drive(1'b1, FUNC_MULT, 32'd2, 32'd2);
    @(posedge clk);
    #1;
    drive(1'b0, 6'b0, 32'h0, 32'h0);
    check32("start_in_done_ignored", {31'b0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check32("held_lo_after_ignored", lo, 32'h00123450);
    run_mult(32'd2, 32'd2, 32'h0, 32'h4);

    run_mult(32'd7, 32'd6, 32'h0, 32'h2A);
    issue_mult(32'd3, 32'd3, 32'h0, 32'h9);
    repeat (5) @(posedge clk);
    #1;
    mf_read(FUNC_MFLO, 32'h2A, "mflo_during_run");
    wait_done();
    @(posedge clk);
    #1;
    mf_read(FUNC_MFLO, 32'h9, "mflo_after_done");

    issue_mult(32'd5, 32'd5, 32'h0, 32'd25);
    repeat (13) @(posedge clk);
    sb.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check32("abort_busy", {31'b0, busy}, 32'h0);
    check32("abort_done", {31'b0, done}, 32'h0);
    check32("abort_hi", hi, 32'h0);
    check32("abort_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_mult(32'hFFFFFFF9, 32'hFFFFFFF8, 32'h0, 32'h00000038);

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
Multi-cycle signed multiplier with architectural HI/LO registers. It executes R-type MULT and services MFHI/MFLO in the single-cycle MIPS datapath. It sits beside the ALU and is fed by the same opcode/function fields used by ALU control. While it is busy, the control path stalls instruction fetch.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
inst_valid  input  1  current instruction fields are valid this cycle.
opcode  input  6  instruction opcode field.
instFunc  input  6  instruction function field.
op_a  input  WIDTH  rs value, two's complement.
op_b  input  WIDTH  rt value, two's complement.
busy  output  1  multiply in progress; control stalls on this.
done  output  1  one-cycle pulse when HI/LO are updated.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
rd_data  output  WIDTH  MFHI/MFLO result to the writeback mux.
mf_valid  output  1  current instruction is MFHI or MFLO.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset:
  - FSM goes to IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Internal accumulator, multiplicand, multiplier and counter are cleared to 0.
  - A reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- Decode:
  - start = inst_valid & opcode==000000 & instFunc==011000 (MULT).
  - mf_valid = inst_valid & opcode==000000 & instFunc in {010000 MFHI, 010010 MFLO}.
  - rd_data is combinational: hi when instFunc==010000, otherwise lo.
- FSM states IDLE, RUN, DONE:
  - IDLE: on start, latch |op_a|, |op_b| and neg = op_a[W-1]^op_b[W-1]. Clear the accumulator, load the counter with WIDTH-1, go to RUN.
  - RUN: busy=1. Each cycle, if multiplier LSB=1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right; counter decrements.
  - RUN exit: on the edge where counter==0, write {hi,lo} = neg ? -acc : acc and go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge N; busy high during cycles N+1 .. N+WIDTH; HI/LO new and done=1 in cycle N+WIDTH+1.
- Start acceptance:
  - start is accepted only in IDLE.
  - start in RUN or DONE is ignored, with no queueing.
  - Control holds the MULT instruction while busy, so it is never lost.
- Reads during an operation: hi/lo hold the previous result for the whole of RUN; MFHI/MFLO in RUN return old values.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned. |-2^(W-1)| = 2^(W-1) fits.
  - The accumulator is 2*WIDTH bits and the final negation is mod 2^(2W).
  - (-2^(W-1))^2 = 2^(2W-2) is representable.
  - A zero operand still takes the full WIDTH cycles (no early exit).
- Undefined encodings: no X is driven on outputs; all outputs are always driven from registers or a defined mux.

Decomposition:
- Shared package mips_defs:
  - OPCODE_RTYPE.
  - FUNC_MULT, FUNC_MFHI, FUNC_MFLO, plus the existing FUNC_* and OP_* codes.
  - FSM state encoding for mult_hilo_unit.
- One sub-module, mult_shift_add_core: the shift-add datapath with inputs load, step, mcand, mplier and output acc.
- mult_hilo_unit keeps the FSM, counter, sign handling, HI/LO registers and read mux.

Test Plan:
- Basic multiply: rst pulse, then MULT 7*6 → busy for 32 cycles, done in cycle 33; hi=0x00000000, lo=0x0000002A.
- Mixed signs: MULT -3 (0xFFFFFFFD) * 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MFHI rd_data=0xFFFFFFFF, MFLO rd_data=0xFFFFFFF1, mf_valid=1.
- Most-negative squared: MULT 0x80000000*0x80000000 → hi=0x40000000, lo=0x00000000. Also 0x7FFFFFFF*0x80000000 → hi=0xC0000000, lo=0x80000000.
- Start while busy: second MULT 2*2 asserted at cycle 10 of RUN → ignored; after done the first result stands; a new start is accepted only in IDLE.
- Reads during RUN: after 7*6 completes, issue 3*3 and read MFLO during RUN → 0x2A; after done → 0x9.
- Reset mid-operation: assert rst at cycle 15 of RUN → busy, done, hi, lo go to 0 immediately (asynchronous, before the next edge); the next MULT runs normally.
